// File: rtl/riscv_alu_issue_pkg.sv
// riscv_alu_issue_pkg: ALU control codes, opcodes and issue-state types shared by the issue slice
package riscv_alu_issue_pkg;
  localparam int XLEN = 32;
  localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
  localparam logic [3:0] ALU_CTRL_XOR  = 4'd2;
  localparam logic [3:0] ALU_CTRL_OR   = 4'd3;
  localparam logic [3:0] ALU_CTRL_AND  = 4'd4;
  localparam logic [3:0] ALU_CTRL_SLL  = 4'd5;
  localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
  localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'd8;
  localparam logic [3:0] ALU_CTRL_SLTU = 4'd9;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} issue_state_e;
  // alt selects SUB/SRA on the funct3 slots that have an alternate operation
  function automatic logic [3:0] alu_f3_ctrl(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_CTRL_SUB : ALU_CTRL_ADD;
      3'b001:  return ALU_CTRL_SLL;
      3'b010:  return ALU_CTRL_SLT;
      3'b011:  return ALU_CTRL_SLTU;
      3'b100:  return ALU_CTRL_XOR;
      3'b101:  return alt ? ALU_CTRL_SRA : ALU_CTRL_SRL;
      3'b110:  return ALU_CTRL_OR;
      default: return ALU_CTRL_AND;
    endcase
  endfunction
endpackage

// File: rtl/riscv_alu_issue_decode.sv
// riscv_alu_decode: combinational RV32I decode into ALU operands, control and writeback info
module riscv_alu_decode #(
  parameter int XLEN = riscv_alu_issue_pkg::XLEN
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);
  import riscv_alu_issue_pkg::*;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt, a, b;
  logic [3:0] ctrl;
  logic shift, bad, we;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign shift  = funct3 == 3'b001 || funct3 == 3'b101;
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign shamt  = XLEN'(instr[24:20]);
  always_comb begin
    a    = '0;
    b    = '0;
    ctrl = ALU_CTRL_ADD;
    we   = 1'b1;
    bad  = 1'b0;
    case (opcode)
      OPCODE_OP: begin
        a    = rs1;
        b    = rs2;
        ctrl = alu_f3_ctrl(funct3, instr[30]);
        bad  = !(funct7 == 7'b0000000 || (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPCODE_OP_IMM: begin
        a    = rs1;
        b    = shift ? shamt : imm_i;
        ctrl = alu_f3_ctrl(funct3, shift && instr[30]);
        bad  = shift && !(funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b101));
      end
      OPCODE_LUI: b = imm_u;
      OPCODE_AUIPC: begin
        a = pc;
        b = imm_u;
      end
      OPCODE_LOAD: begin
        a = rs1;
        b = imm_i;
      end
      OPCODE_STORE: begin
        a  = rs1;
        b  = imm_s;
        we = 1'b0;
      end
      OPCODE_BRANCH: begin
        a    = rs1;
        b    = rs2;
        we   = 1'b0;
        ctrl = !funct3[2] ? ALU_CTRL_SUB : funct3[1] ? ALU_CTRL_SLTU : ALU_CTRL_SLT;
        bad  = funct3[2:1] == 2'b01;
      end
      default: bad = 1'b1;
    endcase
  end
  // illegal encodings still issue, but as a harmless ADD 0,0 with no writeback
  assign illegal  = bad;
  assign alu_a    = bad ? '0 : a;
  assign alu_b    = bad ? '0 : b;
  assign alu_ctrl = bad ? ALU_CTRL_ADD : ctrl;
  assign rd       = instr[11:7];
  assign rd_we    = we && !bad && |rd;
endmodule

// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue: ALU issue stage with a two-entry skid buffer at the ID/EX boundary
module riscv_alu_issue #(
  parameter int XLEN = riscv_alu_issue_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_id_valid,
  output logic            o_id_ready,
  input  logic [31:0]     i_id_instr,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [XLEN-1:0] i_id_rs1_data,
  input  logic [XLEN-1:0] i_id_rs2_data,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [XLEN-1:0] o_ex_alu_a,
  output logic [XLEN-1:0] o_ex_alu_b,
  output logic [3:0]      o_ex_alu_ctrl,
  output logic [4:0]      o_ex_rd,
  output logic            o_ex_rd_we,
  output logic            o_ex_illegal
);
  import riscv_alu_issue_pkg::*;
  localparam int PW = 2*XLEN + 11;
  issue_state_e state, state_nxt;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [3:0] dec_ctrl;
  logic [4:0] dec_rd;
  logic dec_we, dec_ill, in_fire, out_fire;
  logic [PW-1:0] dec, out_q, skid_q;
  riscv_alu_decode #(.XLEN(XLEN)) u_decode (
    .instr    (i_id_instr),
    .pc       (i_id_pc),
    .rs1      (i_id_rs1_data),
    .rs2      (i_id_rs2_data),
    .alu_a    (dec_a),
    .alu_b    (dec_b),
    .alu_ctrl (dec_ctrl),
    .rd       (dec_rd),
    .rd_we    (dec_we),
    .illegal  (dec_ill)
  );
  assign dec      = {dec_a, dec_b, dec_ctrl, dec_rd, dec_we, dec_ill};
  assign in_fire  = i_id_valid && o_id_ready;
  assign out_fire = o_ex_valid && i_ex_ready;
  always_ff @(posedge i_clk)
    if (i_rst) state <= ST_EMPTY;
    else state <= state_nxt;
  always_comb
    state_nxt = i_flush ? ST_EMPTY :
                state == ST_EMPTY ? (in_fire ? ST_ONE : ST_EMPTY) :
                state == ST_ONE ? (in_fire && !out_fire ? ST_FULL : !in_fire && out_fire ? ST_EMPTY : ST_ONE) :
                (out_fire ? ST_ONE : ST_FULL);
  // both flags decode straight from the state flops, so neither sees i_ex_ready or i_id_* combinationally
  always_comb begin
    o_ex_valid = state != ST_EMPTY;
    o_id_ready = state != ST_FULL;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (out_fire && state == ST_FULL) out_q <= skid_q;
      else if (in_fire && (state == ST_EMPTY || out_fire)) out_q <= dec;
      if (in_fire && state == ST_ONE && !out_fire) skid_q <= dec;
    end
  assign {o_ex_alu_a, o_ex_alu_b, o_ex_alu_ctrl, o_ex_rd, o_ex_rd_we, o_ex_illegal} = out_q;
endmodule

// File: tb/tb_riscv_alu_issue.sv
// tb_riscv_alu_issue: directed and random checks of the issue stage against a queue-based reference
module tb_riscv_alu_issue;
  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        we, ill;
  } pl_t;
  logic i_clk, i_rst, i_flush, i_id_valid, o_id_ready, o_ex_valid, i_ex_ready;
  logic [31:0] i_id_instr, i_id_pc, i_id_rs1_data, i_id_rs2_data, o_ex_alu_a, o_ex_alu_b;
  logic [3:0] o_ex_alu_ctrl;
  logic [4:0] o_ex_rd;
  logic o_ex_rd_we, o_ex_illegal;
  int checks = 0, failures = 0;
  pl_t q[$];
  logic mready = 1'b1;
  riscv_alu_issue #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_id_valid(i_id_valid), .o_id_ready(o_id_ready), .i_id_instr(i_id_instr),
    .i_id_pc(i_id_pc), .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
    .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready), .o_ex_alu_a(o_ex_alu_a),
    .o_ex_alu_b(o_ex_alu_b), .o_ex_alu_ctrl(o_ex_alu_ctrl), .o_ex_rd(o_ex_rd),
    .o_ex_rd_we(o_ex_rd_we), .o_ex_illegal(o_ex_illegal)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic pl_t ref_decode(input logic [31:0] ins, pc, rs1, rs2);
    pl_t p;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ok, shift;
    logic [3:0] base [8];
    base = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ok = 1'b1; shift = f3 == 3'd1 || f3 == 3'd5;
    p.a = 0; p.b = 0; p.ctrl = 0; p.rd = ins[11:7]; p.we = 1'b1; p.ill = 1'b0;
    case (op)
      7'h33: begin
        ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        p.a = rs1; p.b = rs2;
        p.ctrl = f7 != 7'h00 ? (f3 == 3'd0 ? 4'd1 : 4'd7) : base[f3];
      end
      7'h13: begin
        ok = !shift || f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5);
        p.a = rs1;
        p.b = shift ? {27'b0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
        p.ctrl = (f3 == 3'd5 && f7 == 7'h20) ? 4'd7 : base[f3];
      end
      7'h37: p.b = {ins[31:12], 12'h000};
      7'h17: begin p.a = pc; p.b = {ins[31:12], 12'h000}; end
      7'h03: begin p.a = rs1; p.b = {{20{ins[31]}}, ins[31:20]}; end
      7'h23: begin p.a = rs1; p.b = {{20{ins[31]}}, ins[31:25], ins[11:7]}; p.we = 1'b0; end
      7'h63: begin
        p.a = rs1; p.b = rs2; p.we = 1'b0;
        ok = f3 != 3'd2 && f3 != 3'd3;
        p.ctrl = f3 < 3'd2 ? 4'd1 : f3 < 3'd6 ? 4'd8 : 4'd9;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin p.a = 0; p.b = 0; p.ctrl = 0; p.we = 1'b0; p.ill = 1'b1; end
    if (p.rd == 5'd0) p.we = 1'b0;
    return p;
  endfunction
  task automatic check_outputs();
    check("ex_valid", o_ex_valid, q.size() > 0);
    check("id_ready", o_id_ready, mready);
    if (q.size() > 0) begin
      check("alu_a", o_ex_alu_a, q[0].a);
      check("alu_b", o_ex_alu_b, q[0].b);
      check("alu_ctrl", o_ex_alu_ctrl, q[0].ctrl);
      check("rd", o_ex_rd, q[0].rd);
      check("rd_we", o_ex_rd_we, q[0].we);
      check("illegal", o_ex_illegal, q[0].ill);
    end
  endtask
  // called with clk low; applies one cycle of stimulus, advances the model, checks at the next negedge
  task automatic step(input logic v, input logic [31:0] ins, pc, rs1, rs2, input logic er, fl, rs);
    logic in_f, out_f;
    i_id_valid = v; i_id_instr = ins; i_id_pc = pc; i_id_rs1_data = rs1; i_id_rs2_data = rs2;
    i_ex_ready = er; i_flush = fl; i_rst = rs;
    in_f = v && mready;
    out_f = q.size() > 0 && er;
    @(posedge i_clk);
    if (rs || fl) begin
      q.delete();
      mready = 1'b1;
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(ref_decode(ins, pc, rs1, rs2));
      mready = q.size() < 2;
    end
    @(negedge i_clk);
    check_outputs();
  endtask
  task automatic expect_pl(input string tag, input logic [31:0] a, b, input logic [3:0] ctrl,
                           input logic [4:0] rd, input logic we, ill);
    check({tag, "_a"}, o_ex_alu_a, a);
    check({tag, "_b"}, o_ex_alu_b, b);
    check({tag, "_ctrl"}, o_ex_alu_ctrl, ctrl);
    check({tag, "_rd"}, o_ex_rd, rd);
    check({tag, "_we"}, o_ex_rd_we, we);
    check({tag, "_ill"}, o_ex_illegal, ill);
  endtask
  function automatic logic [31:0] addi_rd(input logic [4:0] rd);
    return 32'h00500013 | (32'(rd) << 7);
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [8];
    logic [6:0] op, f7;
    int r;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h7f};
    op = ops[$urandom_range(0, 7)];
    if (op == 7'h7f) op = 7'($urandom);
    r = $urandom_range(0, 2);
    f7 = r == 0 ? 7'h00 : r == 1 ? 7'h20 : 7'($urandom);
    return {f7, 10'($urandom), 3'($urandom), 5'($urandom), op};
  endfunction
  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_id_valid = 1'b0; i_ex_ready = 1'b0;
    i_id_instr = 0; i_id_pc = 0; i_id_rs1_data = 0; i_id_rs2_data = 0;
    @(negedge i_clk);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    expect_pl("reset", 0, 0, 0, 0, 0, 0);
    step(1, 32'h00500093, 32'h100, 0, 0, 1, 0, 0);
    expect_pl("addi", 0, 5, 0, 1, 1, 0);
    step(1, 32'h402080B3, 0, 7, 3, 1, 0, 0);
    expect_pl("sub", 7, 3, 1, 1, 1, 0);
    step(1, 32'h4041D193, 0, 32'h80000000, 0, 1, 0, 0);
    check("srai_ctrl", o_ex_alu_ctrl, 7);
    check("srai_b", o_ex_alu_b, 4);
    step(1, 32'h123452B7, 0, 9, 9, 1, 0, 0);
    expect_pl("lui", 0, 32'h12345000, 0, 5, 1, 0);
    step(1, 32'hFE20AE23, 0, 32'h1000, 0, 1, 0, 0);
    check("sw_b", o_ex_alu_b, 32'hFFFFFFFC);
    check("sw_we", o_ex_rd_we, 0);
    step(1, 32'h00000000, 4, 5, 6, 1, 0, 0);
    expect_pl("ill0", 0, 0, 0, 0, 0, 1);
    step(1, 32'h0220C0B3, 4, 5, 6, 1, 0, 0);
    expect_pl("ill_f7", 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(1, addi_rd(1), 0, 0, 0, 0, 0, 0);
    check("bp1_rd", o_ex_rd, 1);
    step(1, addi_rd(2), 0, 0, 0, 0, 0, 0);
    check("bp2_ready", o_id_ready, 0);
    check("bp2_rd", o_ex_rd, 1);
    step(1, addi_rd(3), 0, 0, 0, 0, 0, 0);
    check("bp3_ready", o_id_ready, 0);
    check("bp3_rd", o_ex_rd, 1);
    step(1, addi_rd(3), 0, 0, 0, 1, 0, 0);
    check("drain_b", o_ex_rd, 2);
    step(1, addi_rd(3), 0, 0, 0, 1, 0, 0);
    check("drain_c", o_ex_rd, 3);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("drain_end", o_ex_valid, 0);
    step(1, addi_rd(4), 0, 0, 0, 0, 0, 0);
    step(1, addi_rd(5), 0, 0, 0, 0, 0, 0);
    step(1, addi_rd(9), 0, 0, 0, 0, 1, 0);
    check("flush_valid", o_ex_valid, 0);
    check("flush_ready", o_id_ready, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("flush_drop", o_ex_valid, 0);
    step(1, addi_rd(6), 0, 0, 0, 0, 0, 0);
    step(1, addi_rd(7), 0, 0, 0, 0, 0, 0);
    step(1, addi_rd(9), 0, 0, 0, 0, 0, 1);
    check("rst_valid", o_ex_valid, 0);
    check("rst_ready", o_id_ready, 1);
    expect_pl("rst_mid", 0, 0, 0, 0, 0, 0);
    step(1, 32'h00500093, 0, 0, 0, 1, 0, 0);
    expect_pl("post_rst", 0, 5, 0, 1, 1, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_alu_issue.md
# riscv_alu_issue

Issue stage that drives the RV32I ALU.
- Accepts decoded-stage instructions over a valid/ready handshake and decodes opcode/funct3/funct7 into the `ALU_CTRL_*` code.
- Selects and extends the ALU operands (rs1/rs2/imm/pc) and registers them into the ID/EX boundary.
- A two-entry skid buffer gives a registered `o_id_ready` and full throughput under EX backpressure.

## Interface
Parameters:
- `XLEN`, `` `XLEN`` (32): datapath width, from riscv_configs.v.

Ports. One clock; reset is synchronous and active-high.
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous active-high reset.
- `i_flush` in 1: kill all held and incoming work.
- `i_id_valid` in 1: ID offers an instruction.
- `o_id_ready` out 1: issue can accept. Registered.
- `i_id_instr` in 32: instruction word.
- `i_id_pc` in XLEN: PC of the instruction.
- `i_id_rs1_data` in XLEN: rs1 read data.
- `i_id_rs2_data` in XLEN: rs2 read data.
- `o_ex_valid` out 1: EX payload valid.
- `i_ex_ready` in 1: EX consumes the payload.
- `o_ex_alu_a` out XLEN: ALU operand A.
- `o_ex_alu_b` out XLEN: ALU operand B.
- `o_ex_alu_ctrl` out 4: `ALU_CTRL_*` code.
- `o_ex_rd` out 5: destination register.
- `o_ex_rd_we` out 1: register write enable.
- `o_ex_illegal` out 1: unsupported encoding.

## Operation
ALU control encodings are defined in riscv_configs.v: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.

Immediates:
- I-type: sext(instr[31:20]).
- S-type: sext({instr[31:25],instr[11:7]}).
- U-type: {instr[31:12],12'b0}.
- Shift amount: zero-extended instr[24:20].

Decode by opcode:
- **OP (0110011):** a=rs1, b=rs2. funct3 maps 000 ADD/SUB (instr[30]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (instr[30]), 110 OR, 111 AND. funct7 must be 0000000, or 0100000 only with funct3 000/101; anything else is illegal.
- **OP-IMM (0010011):** a=rs1, b=I-imm, same funct3 map, but 000 is always ADD. For funct3 001/101, b=shamt and instr[31:25] must be 0000000 (SLLI/SRLI) or 0100000 (SRAI only); anything else is illegal.
- **LUI (0110111):** a=0, b=U-imm, ADD.
- **AUIPC (0010111):** a=pc, b=U-imm, ADD.
- **LOAD (0000011):** a=rs1, b=I-imm, ADD.
- **STORE (0100011):** a=rs1, b=S-imm, ADD, rd_we=0.
- **BRANCH (1100011):** a=rs1, b=rs2, rd_we=0. funct3 000/001 SUB, 100/101 SLT, 110/111 SLTU; 010/011 are illegal.
- **Any other opcode:** illegal.
- **Illegal instructions** still issue, with ctrl=ADD, a=b=0, rd_we=0, illegal=1.
- **rd and rd_we:** rd = instr[11:7]. rd_we is forced to 0 when rd==0.

Skid buffer, with entries OUT and SKID:
- Transfer in when `i_id_valid && o_id_ready`. Transfer out when `o_ex_valid && i_ex_ready`.
- Next `o_id_ready` = !next SKID-valid.
- States:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: both valid.
- Transitions:
  - EMPTY + in → ONE.
  - ONE + in + out → ONE (OUT replaced).
  - ONE + in, no out → FULL (payload goes to SKID).
  - ONE + out, no in → EMPTY.
  - FULL + out → ONE (SKID moves to OUT).
  - FULL cannot accept, because `o_id_ready`=0.
- Order is strictly preserved. OUT payload is held stable while `o_ex_valid && !i_ex_ready`.
- **Flush** takes priority over everything. Both entries are invalidated next cycle, and any input accepted in the flush cycle is dropped. Next state is EMPTY with `o_id_ready`=1.

## Timing
- **Reset:** `o_ex_valid`=0 and `o_id_ready`=1 from the first clock edge with `i_rst` high. All payload outputs are 0 (alu_a, alu_b, alu_ctrl=ADD, rd, rd_we, illegal).
- **Reset mid-operation:** behaves identically to reset from idle. Held entries are discarded.
- **Latency:** instruction accepted at edge N appears on `o_ex_*` after edge N (valid in cycle N+1) when OUT is empty or draining.
- **Throughput:** 1 instruction/cycle sustained with `i_ex_ready`=1.
- **Backpressure:** at most 2 instructions absorbed. `o_id_ready` falls the cycle after SKID fills.
- **Dependencies:** no combinational path from `i_ex_ready` to `o_id_ready`, and none from `i_id_*` to `o_ex_*`.

## Structure
- riscv_configs.v holds the `ALU_CTRL_*` encodings, `XLEN`, and new `OPCODE_*` constants (OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH).
- Sub-module `riscv_alu_decode` is purely combinational. Inputs: instr, pc, rs1, rs2. Outputs: the a/b/ctrl/rd/rd_we/illegal payload.
- The top level holds the two payload registers and the state logic only.

## Test plan
- **ADDI:** instr 0x00500093, rs1=0, `i_ex_ready`=1 → next cycle a=0, b=5, ctrl=0, rd=1, rd_we=1, illegal=0.
- **Decode sweep:**
  - 0x402080B3 (sub) with rs1=7, rs2=3 → ctrl=1, a=7, b=3.
  - 0x4041D193 (srai) → ctrl=7, b=4.
  - 0x123452B7 (lui) → a=0, b=0x12345000, rd=5.
  - 0xFE20AE23 (sw) → b=0xFFFFFFFC, rd_we=0.
- **Backpressure:** offer 3 back-to-back instructions with `i_ex_ready`=0 → `o_id_ready` deasserts after 2 are accepted and OUT stays on the first. Raising `i_ex_ready` drains all 3 in order on consecutive cycles.
- **Flush:** hold FULL state, pulse `i_flush` with `i_id_valid`=1 → next cycle `o_ex_valid`=0, `o_id_ready`=1, and the flush-cycle input never appears.
- **Illegal:** instr 0x00000000 and 0x0220C0B3 (funct7=1) → illegal=1, ctrl=0, a=b=0, rd_we=0.
- **Reset:** assert `i_rst` mid-stream in FULL state → all outputs at reset values on the next cycle, then 0x00500093 issues normally.
